// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: response owner tag and access sizes.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DATA = 2'd2
    } owner_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side bus bundle of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              if_stall;

    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_size;
    logic              d_sign;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic              d_stall;
    logic              err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic              mem_sign;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_size, d_sign, mem_rdata,
        output if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall, err,
        output mem_addr, mem_wdata, mem_rd, mem_wr, mem_size, mem_sign
    );

    modport master (
        output if_req, if_addr, d_rd, d_wr, d_addr, d_wdata, d_size, d_sign, mem_rdata,
        input  if_rdata, if_valid, if_stall, d_rdata, d_valid, d_stall, err,
        input  mem_addr, mem_wdata, mem_rd, mem_wr, mem_size, mem_sign
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive fetch denials and forces a fetch grant once STARVE_MAX is reached.
module mem_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_force_c
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign o_force_c = i_if_req & (r_cnt == CNT_W'(STARVE_MAX));

    // Fetch is denied only while data wins without a force; any grant or idle clears
    always_comb begin
        w_cnt_nxt = '0;
        if (i_if_req & i_d_req & ~o_force_c) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch and data; data wins by default.
// Build option ARB_STARVE_GUARD_EN adds a forced fetch grant after STARVE_MAX denials.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic               CLK,
    input  logic               RST,
    mem_port_arbiter_if.slave  bus
);

    if (STARVE_MAX == 0) begin : g_starve_max_chk
        $error("STARVE_MAX must be at least 1");
    end

    logic              w_d_req;
    logic              w_d_gnt;
    logic              w_if_gnt;
    logic              w_force;

    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_mem_rd;
    logic              w_mem_wr;
    logic [1:0]        w_mem_size;
    logic              w_mem_sign;

    owner_t            r_owner;
    owner_t            w_owner_nxt;
    logic              r_is_load;
    logic              w_is_load_nxt;
    logic              r_err;

    assign w_d_req = bus.d_rd | bus.d_wr;

`ifdef ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .i_clk     (CLK),
        .i_rst     (RST),
        .i_if_req  (bus.if_req),
        .i_d_req   (w_d_req),
        .o_force_c (w_force)
    );
`else
    assign w_force = 1'b0;
`endif

    assign w_d_gnt  = w_d_req & ~w_force;
    assign w_if_gnt = bus.if_req & (~w_d_req | w_force);

    assign bus.if_stall = bus.if_req & ~w_if_gnt;
    assign bus.d_stall  = w_d_req & ~w_d_gnt;

    // Memory-side mux; rd+wr together is handled as a store
    always_comb begin
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_mem_rd    = 1'b0;
        w_mem_wr    = 1'b0;
        w_mem_size  = '0;
        w_mem_sign  = 1'b0;
        if (w_d_gnt) begin
            w_mem_addr  = bus.d_addr;
            w_mem_wdata = bus.d_wdata;
            w_mem_rd    = ~bus.d_wr;
            w_mem_wr    = bus.d_wr;
            w_mem_size  = bus.d_size;
            w_mem_sign  = bus.d_sign;
        end else if (w_if_gnt) begin
            w_mem_addr  = bus.if_addr;
            w_mem_rd    = 1'b1;
            w_mem_size  = SZ_WORD;
        end
    end

    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.mem_rd    = w_mem_rd;
    assign bus.mem_wr    = w_mem_wr;
    assign bus.mem_size  = w_mem_size;
    assign bus.mem_sign  = w_mem_sign;

    always_comb begin
        w_owner_nxt   = NONE;
        w_is_load_nxt = 1'b0;
        if (w_d_gnt) begin
            w_owner_nxt   = DATA;
            w_is_load_nxt = ~bus.d_wr;
        end else if (w_if_gnt) begin
            w_owner_nxt   = IF;
        end
    end

    // Reset discards any response still owed for the previous cycle's grant
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_owner   <= NONE;
            r_is_load <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_owner   <= w_owner_nxt;
            r_is_load <= w_is_load_nxt;
            r_err     <= r_err | (bus.d_rd & bus.d_wr);
        end
    end

    assign bus.if_valid = (r_owner == IF);
    assign bus.if_rdata = (r_owner == IF) ? bus.mem_rdata : '0;
    assign bus.d_valid  = (r_owner == DATA);
    assign bus.d_rdata  = ((r_owner == DATA) && r_is_load) ? bus.mem_rdata : '0;
    assign bus.err      = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    bit [7:0] dev_mem [0:65535];
    bit [7:0] ref_mem [0:65535];

    int n_tests = 0;
    int n_fail  = 0;

    logic        pend_ifv, pend_dv, m_err, m_if_stall, m_d_stall;
    logic [31:0] pend_ifd, pend_dd;
    int          m_starve;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] sz, input logic sg);
        case (sz)
            SZ_BYTE: return sg ? {{24{w[7]}}, w[7:0]} : {24'h0, w[7:0]};
            SZ_HALF: return sg ? {{16{w[15]}}, w[15:0]} : {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [1:0] sz, input logic sg);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[16'(a + 32'(k))];
        return fmt_load(w, sz, sg);
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        for (int k = 0; k < size_bytes(sz); k++) ref_mem[16'(a + 32'(k))] = wd[8*k +: 8];
    endfunction

    // Byte-addressed synchronous memory answering the arbiter's strobes
    always @(posedge clk) begin
        logic [31:0] w;
        if (bus.mem_wr) begin
            for (int k = 0; k < size_bytes(bus.mem_size); k++)
                dev_mem[16'(bus.mem_addr + 32'(k))] <= bus.mem_wdata[8*k +: 8];
        end
        if (bus.mem_rd) begin
            for (int k = 0; k < 4; k++) w[8*k +: 8] = dev_mem[16'(bus.mem_addr + 32'(k))];
            bus.mem_rdata <= fmt_load(w, bus.mem_size, bus.mem_sign);
        end
    end

    task automatic set_inputs(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                              input logic [31:0] da, input logic [31:0] wd, input logic [1:0] sz,
                              input logic sg);
        bus.if_req  = ir;
        bus.if_addr = ia;
        bus.d_rd    = dr;
        bus.d_wr    = dw;
        bus.d_addr  = da;
        bus.d_wdata = wd;
        bus.d_size  = sz;
        bus.d_sign  = sg;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_inputs(1'b0, '0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        #1;
        check("rst_if_valid", 32'(bus.if_valid), 32'd0);
        check("rst_d_valid",  32'(bus.d_valid),  32'd0);
        check("rst_err",      32'(bus.err),      32'd0);
        check("rst_if_rdata", bus.if_rdata,      32'd0);
        check("rst_d_rdata",  bus.d_rdata,       32'd0);
        pend_ifv = 1'b0; pend_dv = 1'b0; pend_ifd = '0; pend_dd = '0;
        m_err = 1'b0; m_starve = 0; m_if_stall = 1'b0; m_d_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // One bus cycle: verify last cycle's response, apply requests, verify the grant
    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] wd, input logic [1:0] sz,
                         input logic sg);
        logic        dreq, frc, dg, ig, e_rd, e_wr, e_sg, n_ifv, n_dv;
        logic [31:0] e_addr, e_wdata, n_ifd, n_dd;
        logic [1:0]  e_sz;

        check("if_valid", 32'(bus.if_valid), 32'(pend_ifv));
        check("if_rdata", bus.if_rdata,      pend_ifd);
        check("d_valid",  32'(bus.d_valid),  32'(pend_dv));
        check("d_rdata",  bus.d_rdata,       pend_dd);
        check("err",      32'(bus.err),      32'(m_err));

        set_inputs(ir, ia, dr, dw, da, wd, sz, sg);

        dreq = dr | dw;
`ifdef ARB_STARVE_GUARD_EN
        frc = ir && (m_starve == int'(SMAX));
`else
        frc = 1'b0;
`endif
        dg = dreq && !frc;
        ig = ir && (!dreq || frc);
        m_err = m_err | (dr & dw);

        e_addr = '0; e_wdata = '0; e_rd = 1'b0; e_wr = 1'b0; e_sz = 2'b00; e_sg = 1'b0;
        n_ifv = 1'b0; n_ifd = '0; n_dv = 1'b0; n_dd = '0;
        if (dg) begin
            e_addr = da; e_wdata = wd; e_wr = dw; e_rd = !dw; e_sz = sz; e_sg = sg;
            n_dv = 1'b1;
            if (dw) ref_write(da, wd, sz);
            else    n_dd = ref_read(da, sz, sg);
        end else if (ig) begin
            e_addr = ia; e_rd = 1'b1; e_sz = SZ_WORD;
            n_ifv = 1'b1;
            n_ifd = ref_read(ia, SZ_WORD, 1'b0);
        end
        m_starve   = (!ir || ig) ? 0 : m_starve + 1;
        m_if_stall = ir && !ig;
        m_d_stall  = dreq && !dg;

        @(negedge clk);
        check("mem_addr",  bus.mem_addr,          e_addr);
        check("mem_wdata", bus.mem_wdata,         e_wdata);
        check("mem_rd",    32'(bus.mem_rd),       32'(e_rd));
        check("mem_wr",    32'(bus.mem_wr),       32'(e_wr));
        check("mem_size",  32'(bus.mem_size),     32'(e_sz));
        check("mem_sign",  32'(bus.mem_sign),     32'(e_sg));
        check("if_stall",  32'(bus.if_stall),     32'(m_if_stall));
        check("d_stall",   32'(bus.d_stall),      32'(m_d_stall));

        @(posedge clk);
        #1;
        pend_ifv = n_ifv; pend_ifd = n_ifd; pend_dv = n_dv; pend_dd = n_dd;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
    endtask

    initial begin
        logic        ir, dr, dw, sg;
        logic [31:0] ia, da, wd;
        logic [1:0]  sz;
        int          op;

        do_reset();

        // Fetch only, with the instruction placed through a data store first
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h100, 32'h0050_0093, SZ_WORD, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        check("fetch_valid", 32'(bus.if_valid), 32'd1);
        check("fetch_rdata", bus.if_rdata, 32'h0050_0093);

        // Conflict: data served first, fetch one cycle later
        cycle(1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, '0, SZ_WORD, 1'b0);
        check("conflict_d_valid", 32'(bus.d_valid), 32'd1);
        check("conflict_if_valid", 32'(bus.if_valid), 32'd0);
        cycle(1'b1, 32'h104, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        check("conflict_fetch_later", 32'(bus.if_valid), 32'd1);
        idle();

        // Store then load at the same address, plus a signed byte load
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h3000, 32'hDEAD_BEEF, SZ_WORD, 1'b0);
        check("store_ack_valid", 32'(bus.d_valid), 32'd1);
        check("store_ack_rdata", bus.d_rdata, 32'd0);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h3000, '0, SZ_WORD, 1'b0);
        check("load_word", bus.d_rdata, 32'hDEAD_BEEF);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h3000, '0, SZ_BYTE, 1'b1);
        check("load_sbyte", bus.d_rdata, 32'hFFFF_FFEF);
        idle();

        // Illegal rd+wr acts as a store and latches err
        cycle(1'b0, '0, 1'b1, 1'b1, 32'h3100, 32'h1234_5678, SZ_WORD, 1'b0);
        check("illegal_err", 32'(bus.err), 32'd1);
        idle();
        check("illegal_err_sticky", 32'(bus.err), 32'd1);
        cycle(1'b0, '0, 1'b1, 1'b0, 32'h3100, '0, SZ_WORD, 1'b0);
        check("illegal_was_store", bus.d_rdata, 32'h1234_5678);
        do_reset();

        // Reset right after a fetch grant drops its response
        cycle(1'b1, 32'h100, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
        do_reset();
        idle();

        // Random traffic; stalled requesters hold their fields
        ir = 1'b0; ia = '0; dr = 1'b0; dw = 1'b0; da = '0; wd = '0; sz = SZ_WORD; sg = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!(m_if_stall && ir && $urandom_range(0, 9) != 0)) begin
                ir = 1'($urandom_range(0, 1));
                ia = 32'h1000 + 32'($urandom_range(0, 63)) * 32'd4;
            end
            if (!m_d_stall) begin
                op = $urandom_range(0, 3);
                dr = (op == 1);
                dw = (op == 2);
                da = 32'h1000 + 32'($urandom_range(0, 255));
                wd = $urandom;
                sz = 2'($urandom_range(0, 2));
                sg = 1'($urandom_range(0, 1));
            end
            cycle(ir, ia, dr, dw, da, wd, sz, sg);
        end
        idle();

`ifdef ARB_STARVE_GUARD_EN
        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 32'h1000, 1'b1, 1'b0, 32'h1004, '0, SZ_WORD, 1'b0);
            check("starve_if_valid", 32'(bus.if_valid), 32'(i == 4));
            check("starve_d_valid",  32'(bus.d_valid),  32'(i != 4));
        end
        idle();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
